// File: rtl/bumpy_pkg.sv
// Shared types and constants for the bumpy ball game: FSM state codes,
// tile-type codes and the score increments used when BUMPY_SCORE_EN is set.
package bumpy_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PLAY    = 3'd1,
    ST_RESPAWN = 3'd2,
    ST_WIN     = 3'd3,
    ST_LOSE    = 3'd4
  } game_state_t;

  typedef enum logic [1:0] {
    TILE_BG    = 2'b00,
    TILE_FLOOR = 2'b01,
    TILE_GIFT  = 2'b10,
    TILE_HOLE  = 2'b11
  } tile_t;

  localparam logic [15:0] GIFT_POINTS    = 16'd10;
  localparam logic [15:0] VICTORY_POINTS = 16'd100;

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

endpackage

// File: rtl/frame_event_latch.sv
// Per-frame sticky flag: remembers that a pixel-level event fired at least once
// during the current frame; cleared on startOfFrame and whenever capture is off.
module frame_event_latch (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic sof,
  input  logic evt,
  output logic hit
);

  logic flag_q;

  always_ff @(posedge clk) begin
    if (reset)
      flag_q <= 1'b0;
    else if (sof || !enable)
      flag_q <= 1'b0;
    else if (evt)
      flag_q <= 1'b1;
  end

  // An event coinciding with the closing startOfFrame still belongs to the ending frame.
  assign hit = flag_q | (enable & evt);

endmodule

// File: rtl/bumpy_game_fsm.sv
// Game-flow FSM for the bumpy ball game: IDLE/PLAY/RESPAWN/WIN/LOSE, gift and
// life bookkeeping. Optional score counter under macro BUMPY_SCORE_EN.
module bumpy_game_fsm
  import bumpy_pkg::*;
#(
  parameter int NUM_GIFTS      = 3,
  parameter int NUM_LIVES      = 3,
  parameter int RESPAWN_FRAMES = 60,
  parameter int END_FRAMES     = 90
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        startOfFrame,
  input  logic        start_key,
  input  logic        Remove_Gift,
  input  logic        victory,
  input  logic        Loss,
  output logic        gift_clear,
  output logic [3:0]  gifts_left,
  output logic [2:0]  lives_left,
  output logic [2:0]  game_state,
  output logic        freeze,
  output logic        respawn_pulse,
  output logic [15:0] score
);

  localparam logic [3:0] GIFTS_INIT   = 4'(NUM_GIFTS);
  localparam logic [2:0] LIVES_INIT   = 3'(NUM_LIVES);
  localparam logic [7:0] RESPAWN_LAST = 8'(RESPAWN_FRAMES - 1);
  localparam logic [7:0] END_LAST     = 8'(END_FRAMES - 1);

  game_state_t state_q, state_d;
  logic [7:0]  frame_cnt_q, frame_cnt_d;
  logic [3:0]  gifts_q, gifts_d;
  logic [2:0]  lives_q, lives_d;
  logic        gift_clear_q;
  logic        freeze_q;
  logic        pulse_q, pulse_d;

  logic in_play;
  logic gift_hit, vic_hit, loss_hit;
  logic new_game, gift_take, vic_take;

  assign in_play = (state_q == ST_PLAY);

  frame_event_latch u_gift_latch (
    .clk(clk), .reset(reset), .enable(in_play), .sof(startOfFrame),
    .evt(Remove_Gift), .hit(gift_hit)
  );

  frame_event_latch u_vic_latch (
    .clk(clk), .reset(reset), .enable(in_play), .sof(startOfFrame),
    .evt(victory), .hit(vic_hit)
  );

  frame_event_latch u_loss_latch (
    .clk(clk), .reset(reset), .enable(in_play), .sof(startOfFrame),
    .evt(Loss), .hit(loss_hit)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      frame_cnt_q  <= '0;
      gifts_q      <= GIFTS_INIT;
      lives_q      <= LIVES_INIT;
      gift_clear_q <= 1'b0;
      freeze_q     <= 1'b1;
      pulse_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_cnt_q  <= frame_cnt_d;
      gifts_q      <= gifts_d;
      lives_q      <= lives_d;
      gift_clear_q <= (gifts_q == 4'd0);
      freeze_q     <= (state_d != ST_PLAY);
      pulse_q      <= pulse_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    gifts_d     = gifts_q;
    lives_d     = lives_q;
    pulse_d     = 1'b0;
    new_game    = 1'b0;
    gift_take   = 1'b0;
    vic_take    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (startOfFrame && start_key) begin
          state_d     = ST_PLAY;
          gifts_d     = GIFTS_INIT;
          lives_d     = LIVES_INIT;
          frame_cnt_d = '0;
          pulse_d     = 1'b1;
          new_game    = 1'b1;
        end
      end
      ST_PLAY: begin
        if (startOfFrame) begin
          // gift_clear only moves two cycles after a frame boundary, so here it
          // still holds the value seen at the start of the ending frame.
          if (vic_hit && gift_clear_q) begin
            vic_take    = 1'b1;
            state_d     = ST_WIN;
            frame_cnt_d = '0;
          end else begin
            if (gift_hit && gifts_q != 4'd0) begin
              gift_take = 1'b1;
              gifts_d   = gifts_q - 4'd1;
            end
            if (loss_hit) begin
              frame_cnt_d = '0;
              if (lives_q > 3'd1) begin
                lives_d = lives_q - 3'd1;
                state_d = ST_RESPAWN;
              end else begin
                lives_d = 3'd0;
                state_d = ST_LOSE;
              end
            end
          end
        end
      end
      ST_RESPAWN: begin
        if (startOfFrame) begin
          if (frame_cnt_q == RESPAWN_LAST) begin
            frame_cnt_d = '0;
            state_d     = ST_PLAY;
            pulse_d     = 1'b1;
          end else begin
            frame_cnt_d = frame_cnt_q + 8'd1;
          end
        end
      end
      ST_WIN, ST_LOSE: begin
        if (startOfFrame) begin
          if (frame_cnt_q == END_LAST) begin
            frame_cnt_d = '0;
            state_d     = ST_IDLE;
          end else begin
            frame_cnt_d = frame_cnt_q + 8'd1;
          end
        end
      end
      default: begin
        state_d     = ST_IDLE;
        frame_cnt_d = '0;
      end
    endcase
  end

`ifdef BUMPY_SCORE_EN
  logic [15:0] score_q;

  always_ff @(posedge clk) begin
    if (reset || new_game)
      score_q <= '0;
    else if (vic_take)
      score_q <= sat_add16(score_q, VICTORY_POINTS);
    else if (gift_take)
      score_q <= sat_add16(score_q, GIFT_POINTS);
  end

  assign score = score_q;
`else
  assign score = 16'd0;
`endif

  assign game_state    = state_q;
  assign gifts_left    = gifts_q;
  assign lives_left    = lives_q;
  assign gift_clear    = gift_clear_q;
  assign freeze        = freeze_q;
  assign respawn_pulse = pulse_q;

endmodule

// File: doc/bumpy_game_fsm.md
BUMPY_GAME_FSM -- requirements
Module: bumpy_game_fsm

Interface
REQ-001 Parameter NUM_GIFTS, default 3: gifts per level; range 1..15.
REQ-002 Parameter NUM_LIVES, default 3: lives per game; range 1..7.
REQ-003 Parameter RESPAWN_FRAMES, default 60: frames spent in RESPAWN after a non-final loss; range 1..255.
REQ-004 Parameter END_FRAMES, default 90: frames spent in WIN or LOSE before returning to IDLE; range 1..255.
REQ-005 Ports, one per line (name, direction, width, meaning):
- clk  in  1  system clock; the block has one clock.
- reset  in  1  synchronous, active-high reset.
- startOfFrame  in  1  one-cycle pulse at each frame start.
- start_key  in  1  level input; requests a new game.
- Remove_Gift  in  1  ball overlaps a gift tile; level, asserted per pixel.
- victory  in  1  ball overlaps the hole tile; level, asserted per pixel.
- Loss  in  1  ball hit the losing edge; level, asserted per pixel.
- gift_clear  out  1  high when no gifts remain.
- gifts_left  out  4  gifts still to collect.
- lives_left  out  3  remaining lives.
- game_state  out  3  current state code.
- freeze  out  1  high when ball motion must stop.
- respawn_pulse  out  1  one-cycle pulse that tells the ball to return to its start position.
- score  out  16  accumulated score (see Configuration).

Function
REQ-006 The FSM SHALL have exactly these states and codes: IDLE=0, PLAY=1, RESPAWN=2, WIN=3, LOSE=4.
REQ-007 IDLE -> PLAY SHALL occur on the first startOfFrame with start_key=1; on that transition gifts_left:=NUM_GIFTS, lives_left:=NUM_LIVES, score:=0, and respawn_pulse SHALL pulse.
REQ-008 Event capture SHALL happen in PLAY only. Each of Remove_Gift, victory and Loss SHALL have a per-frame sticky flag: set on any cycle the input is high, cleared on startOfFrame. Each flag SHALL act at most once per frame.
REQ-009 Captured events SHALL be applied on the startOfFrame that ends the frame. Latency is 1 cycle after that pulse.
REQ-010 Gift event SHALL apply only when gifts_left>0. gifts_left SHALL decrement by exactly 1 per frame, SHALL saturate at 0, and SHALL never wrap.
REQ-011 gift_clear SHALL be the registered value of (gifts_left==0).
REQ-012 A victory event SHALL be accepted only if gift_clear was 1 at the start of that frame. Otherwise it SHALL be discarded.
REQ-013 Priority within one frame SHALL be victory > Loss > gift. If victory is accepted, a Loss in the same frame SHALL be ignored. A gift in the same frame as a Loss SHALL still be counted.
REQ-014 An accepted victory SHALL move PLAY -> WIN.
REQ-015 A Loss with lives_left>1 SHALL decrement lives_left and move PLAY -> RESPAWN.
REQ-016 A Loss with lives_left==1 SHALL set lives_left:=0 and move PLAY -> LOSE.
REQ-017 RESPAWN SHALL count RESPAWN_FRAMES startOfFrame pulses, pulse respawn_pulse once, then return to PLAY. Flags SHALL be cleared when PLAY is re-entered.
REQ-018 WIN and LOSE SHALL count END_FRAMES startOfFrame pulses, then go to IDLE. start_key SHALL be ignored in WIN and LOSE.
REQ-019 freeze SHALL be 1 in every state except PLAY.
REQ-020 respawn_pulse SHALL be exactly one clk cycle wide.
REQ-021 All outputs SHALL be registered.

Reset
REQ-022 reset SHALL override all other inputs, including in mid-frame, mid-RESPAWN and mid-WIN/LOSE.
REQ-023 Reset values SHALL be: state=IDLE, gifts_left=NUM_GIFTS, gift_clear=0, lives_left=NUM_LIVES, freeze=1, respawn_pulse=0, score=0, all flags and counters 0.

Configuration
REQ-024 The macro BUMPY_SCORE_EN SHALL control the score logic.
- Defined: score adds 10 per counted gift and 100 per accepted victory, saturating at 16'hFFFF.
- Undefined: no score logic is compiled in, and score is tied to 0.

Structure
REQ-025 The shared package bumpy_pkg SHALL hold the game_state_t enum and the score increment constants. The existing tile-type codes (00 background, 01 floor, 10 gift, 11 hole) SHALL also move into bumpy_pkg.
REQ-026 A sub-module frame_event_latch (sticky flag plus clear-on-startOfFrame) SHALL be instantiated three times, once per event input.

Verification
REQ-027 The bench SHALL cover these directed scenarios:
- Reset, then start_key=1 and one startOfFrame -> state=1, gifts_left=3, lives_left=3, respawn_pulse high for 1 cycle, freeze=0.
- Remove_Gift high for 40 cycles within one frame -> gifts_left decrements by exactly 1 after the next startOfFrame. After 3 such frames: gift_clear=1, gifts_left=0, score=30 (with BUMPY_SCORE_EN).
- victory while gifts_left=2 -> ignored, state stays 1. victory after gift_clear=1 -> state=3, score=130. After 90 frames -> state=0.
- Loss, 3 times in separate frames -> states 2, 1, 2, 1, then 4. lives_left goes 2, 1, 0. respawn_pulse occurs after each 60-frame RESPAWN.
- Loss and victory in the same frame with gift_clear=1 -> state=3 and lives_left unchanged.
- reset asserted mid-RESPAWN -> next cycle state=0, all reset values from REQ-023.
